execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: icode/ifun/register IDs 4 bits, data 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-003 CLOCK_50  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 icode  input  4  instruction code from decode.
REQ-006 ifun  input  4  function code (ALU op or condition).
REQ-007 rA  input  4  register ID A.
REQ-008 rB  input  4  register ID B.
REQ-009 valA  input  32  forwarded operand A.
REQ-010 valB  input  32  forwarded operand B.
REQ-011 valC  input  32  immediate or displacement.
REQ-012 valP  input  32  fall-through PC.
REQ-013 pred  input  1  fetch predicted taken (1) or not taken (0).
REQ-014 out_icode  output  4  registered icode.
REQ-015 out_rA  output  4  registered rA.
REQ-016 out_rB  output  4  registered destination B; 0xF if a cmov is not taken.
REQ-017 out_valA  output  32  registered valA.
REQ-018 out_valE  output  32  registered ALU result.
REQ-019 out_valP  output  32  registered PC for the next stage or for fetch correction.
REQ-020 wrong_pred  output  1  registered branch-misprediction flag to fetch.

Function
REQ-021 All outputs SHALL be registered: inputs are sampled and the results appear one cycle later, so latency is 1 cycle.
REQ-022 Each icode SHALL produce out_valE as follows:
- 0 halt, 1 nop, 7 jXX: 0.
- 2 rrmovl/cmovXX: valA.
- 3 irmovl: valC.
- 4 rmmovl, 5 mrmovl: valB+valC.
- 8 call, A pushl: valB-4.
- 9 ret, B popl: valB+4.
- C-F: 0, with other outputs passed through.
REQ-023 For icode 6 (OPl), out_valE SHALL be determined by ifun:
- 0: valB+valA.
- 1: valB-valA.
- 2: valB&valA.
- 3: valB^valA.
- 4-F: result 0, flags still updated.
REQ-024 All arithmetic SHALL be 32-bit modulo 2^32; carry is discarded.
REQ-025 Internal condition codes ZF, SF and OF SHALL update at the clock edge only for OPl:
- ZF = (result == 0).
- SF = result[31].
- add OF = (a[31]==b[31]) && (r[31]!=b[31]).
- sub OF = (valB[31]!=valA[31]) && (r[31]!=valB[31]).
- and/xor OF = 0.
REQ-026 The condition for jXX/cmov SHALL be evaluated from the CC values before the current instruction, with ifun selecting:
- 0 always.
- 1 le: (SF^OF)|ZF.
- 2 l: SF^OF.
- 3 e: ZF.
- 4 ne: !ZF.
- 5 ge: !(SF^OF).
- 6 g: !(SF^OF)&!ZF.
- 7-F: false.
REQ-027 For icode 2, out_rB SHALL be rB if the condition is true and 0xF otherwise.
REQ-028 For icode 7, wrong_pred SHALL equal (cond != pred), and out_valP SHALL be valC if cond is true and valP otherwise.
REQ-029 For all other icodes, wrong_pred SHALL be 0 and out_valP SHALL be valP.
REQ-030 out_icode, out_rA and out_valA SHALL pass through unchanged; out_rB SHALL pass rB except as stated in REQ-027.
REQ-031 An OPl immediately followed by a jXX SHALL let the jXX see the updated flags.

Reset
REQ-032 While reset is high, the following SHALL hold regardless of the clock:
- out_icode = 1 (nop).
- out_rA = out_rB = 0xF.
- out_valA = out_valE = out_valP = 0.
- wrong_pred = 0.
- ZF = 1, SF = 0, OF = 0.
REQ-033 Reset asserted mid-operation SHALL discard the in-flight result; the first capture SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- OPl add, valA=0x7FFFFFFF, valB=1 -> valE=0x80000000, SF=1, OF=1, ZF=0.
- OPl sub, valA=5, valB=5 -> valE=0, then jXX ifun=3 (je) pred=0, valC=0x100, valP=0x20 -> wrong_pred=1, out_valP=0x100.
- jXX ifun=4 (ne) with ZF=1, pred=0, valP=0x40 -> wrong_pred=0, out_valP=0x40.
- cmovl (icode 2, ifun 2) with SF=OF=0, rB=3 -> out_rB=0xF, out_valE=valA.
- rmmovl with valB=0x1000, valC=8 -> valE=0x1008; pushl with valB=0x200 -> 0x1FC; popl -> 0x204.
- Reset pulse asserted between edges -> outputs go to reset values immediately (no clock edge needed) and ZF=1.

Source files
------------

// File: rtl/execute.sv
// Execute stage: ALU, condition codes, cmov/branch resolution and the registered
// hand-off to the memory stage plus the misprediction signal back to fetch.
module execute (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [31:0] valA,
  input  logic [31:0] valB,
  input  logic [31:0] valC,
  input  logic [31:0] valP,
  input  logic        pred,
  output logic [3:0]  out_icode,
  output logic [3:0]  out_rA,
  output logic [3:0]  out_rB,
  output logic [31:0] out_valA,
  output logic [31:0] out_valE,
  output logic [31:0] out_valP,
  output logic        wrong_pred
);

  logic        zf, sf, of;
  logic [31:0] alu_res;
  logic        alu_of;
  logic        cond;
  logic [31:0] val_e;
  logic [3:0]  next_rb;
  logic [31:0] next_valp;
  logic        next_wrong;

  // OPl datapath; unsupported function codes give zero but still set flags
  always_comb begin
    alu_res = 32'd0;
    alu_of  = 1'b0;
    case (ifun)
      4'h0: begin
        alu_res = valB + valA;
        alu_of  = (valA[31] == valB[31]) && (alu_res[31] != valB[31]);
      end
      4'h1: begin
        alu_res = valB - valA;
        alu_of  = (valB[31] != valA[31]) && (alu_res[31] != valB[31]);
      end
      4'h2: begin
        alu_res = valB & valA;
        alu_of  = 1'b0;
      end
      4'h3: begin
        alu_res = valB ^ valA;
        alu_of  = 1'b0;
      end
      default: begin
        alu_res = 32'd0;
        alu_of  = 1'b0;
      end
    endcase
  end

  // Condition from the flags left by earlier instructions
  always_comb begin
    cond = 1'b0;
    case (ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  // Per-instruction result, destination and PC selection
  always_comb begin
    val_e      = 32'd0;
    next_rb    = rB;
    next_valp  = valP;
    next_wrong = 1'b0;
    case (icode)
      4'h2: begin
        val_e   = valA;
        next_rb = cond ? rB : 4'hF;
      end
      4'h3:       val_e = valC;
      4'h4, 4'h5: val_e = valB + valC;
      4'h6:       val_e = alu_res;
      4'h7: begin
        val_e      = 32'd0;
        next_valp  = cond ? valC : valP;
        next_wrong = cond != pred;
      end
      4'h8, 4'hA: val_e = valB - 32'd4;
      4'h9, 4'hB: val_e = valB + 32'd4;
      default:    val_e = 32'd0;
    endcase
  end

  // Pipeline register and condition-code update
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_icode  <= 4'h1;
      out_rA     <= 4'hF;
      out_rB     <= 4'hF;
      out_valA   <= 32'd0;
      out_valE   <= 32'd0;
      out_valP   <= 32'd0;
      wrong_pred <= 1'b0;
      zf         <= 1'b1;
      sf         <= 1'b0;
      of         <= 1'b0;
    end else begin
      out_icode  <= icode;
      out_rA     <= rA;
      out_rB     <= next_rb;
      out_valA   <= valA;
      out_valE   <= val_e;
      out_valP   <= next_valp;
      wrong_pred <= next_wrong;
      if (icode == 4'h6) begin
        zf <= (alu_res == 32'd0);
        sf <= alu_res[31];
        of <= alu_of;
      end else begin
        zf <= zf;
        sf <= sf;
        of <= of;
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed and random checks of the execute stage against a flag/arithmetic model.
module tb_execute;

  logic        CLOCK_50;
  logic        reset;
  logic [3:0]  icode, ifun, rA, rB;
  logic [31:0] valA, valB, valC, valP;
  logic        pred;
  logic [3:0]  out_icode, out_rA, out_rB;
  logic [31:0] out_valA, out_valE, out_valP;
  logic        wrong_pred;

  int checks = 0;
  int errors = 0;

  // model condition codes
  bit m_zf = 1'b1;
  bit m_sf = 1'b0;
  bit m_of = 1'b0;

  execute dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valA(valA), .valB(valB), .valC(valC), .valP(valP),
    .pred(pred), .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB),
    .out_valA(out_valA), .out_valE(out_valE), .out_valP(out_valP),
    .wrong_pred(wrong_pred)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".icode"}, {28'd0, out_icode}, 32'd1);
    chk({tag, ".rA"},    {28'd0, out_rA},    32'hF);
    chk({tag, ".rB"},    {28'd0, out_rB},    32'hF);
    chk({tag, ".valA"},  out_valA, 32'd0);
    chk({tag, ".valE"},  out_valE, 32'd0);
    chk({tag, ".valP"},  out_valP, 32'd0);
    chk({tag, ".wrong"}, {31'd0, wrong_pred}, 32'd0);
  endtask

  function automatic bit model_cond(input logic [3:0] fn);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (m_sf != m_of) || m_zf;
      4'd2:    return m_sf != m_of;
      4'd3:    return m_zf;
      4'd4:    return !m_zf;
      4'd5:    return m_sf == m_of;
      4'd6:    return (m_sf == m_of) && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction through the stage; expected values come from the model
  task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] p, input logic pr);
    longint sa, sb, wide;
    logic [31:0] e_vale, e_valp;
    logic [3:0]  e_rb;
    bit          e_wrong, cnd, n_of;
    icode = ic; ifun = fn; rA = ra; rB = rb;
    valA = a; valB = b; valC = c; valP = p; pred = pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cnd = model_cond(fn);
    e_vale = 32'd0; e_rb = rb; e_valp = p; e_wrong = 1'b0; n_of = 1'b0;
    case (ic)
      4'h2: begin e_vale = a; if (!cnd) e_rb = 4'hF; end
      4'h3: e_vale = c;
      4'h4, 4'h5: e_vale = b + c;
      4'h6: begin
        wide = 0;
        if (fn == 4'd0) begin e_vale = b + a; wide = sb + sa; end
        else if (fn == 4'd1) begin e_vale = b - a; wide = sb - sa; end
        else if (fn == 4'd2) e_vale = b & a;
        else if (fn == 4'd3) e_vale = b ^ a;
        n_of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'h7: begin e_valp = cnd ? c : p; e_wrong = (cnd != pr); end
      4'h8, 4'hA: e_vale = b - 32'd4;
      4'h9, 4'hB: e_vale = b + 32'd4;
      default: e_vale = 32'd0;
    endcase
    @(posedge CLOCK_50);
    #1;
    if (ic == 4'h6) begin
      m_zf = (e_vale == 32'd0);
      m_sf = e_vale[31];
      m_of = n_of;
    end
    chk({tag, ".icode"}, {28'd0, out_icode}, {28'd0, ic});
    chk({tag, ".rA"},    {28'd0, out_rA},    {28'd0, ra});
    chk({tag, ".rB"},    {28'd0, out_rB},    {28'd0, e_rb});
    chk({tag, ".valA"},  out_valA, a);
    chk({tag, ".valE"},  out_valE, e_vale);
    chk({tag, ".valP"},  out_valP, e_valp);
    chk({tag, ".wrong"}, {31'd0, wrong_pred}, {31'd0, e_wrong});
  endtask

  initial begin
    reset = 1'b0;
    icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0;
    valA = 32'd0; valB = 32'd0; valC = 32'd0; valP = 32'd0; pred = 1'b0;
    #1 reset = 1'b1;
    #1 chk_reset("por");
    #6 reset = 1'b0;
    chk_reset("por_hold");

    // add overflow: 0x7FFFFFFF + 1
    step("add_ovf", 4'h6, 4'h0, 4'h1, 4'h2, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h10, 1'b0);
    step("jne_after_add", 4'h7, 4'h4, 4'hF, 4'hF, 32'd0, 32'd0, 32'h80, 32'h14, 1'b0);
    step("jl_after_add", 4'h7, 4'h2, 4'hF, 4'hF, 32'd0, 32'd0, 32'h90, 32'h18, 1'b1);
    // sub to zero then je resolves taken against a not-taken prediction
    step("sub_zero", 4'h6, 4'h1, 4'h3, 4'h4, 32'd5, 32'd5, 32'd0, 32'h1C, 1'b0);
    step("je_mispred", 4'h7, 4'h3, 4'hF, 4'hF, 32'd0, 32'd0, 32'h100, 32'h20, 1'b0);
    step("jne_zf1", 4'h7, 4'h4, 4'hF, 4'hF, 32'd0, 32'd0, 32'h200, 32'h40, 1'b0);
    step("cmovl_not", 4'h2, 4'h2, 4'h5, 4'h3, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'h44, 1'b0);
    step("cmovle_take", 4'h2, 4'h1, 4'h5, 4'h3, 32'h1234_5678, 32'd0, 32'd0, 32'h46, 1'b0);
    step("rmmovl", 4'h4, 4'h0, 4'h1, 4'h2, 32'd7, 32'h1000, 32'd8, 32'h4C, 1'b0);
    step("pushl", 4'hA, 4'h0, 4'h1, 4'h4, 32'd7, 32'h200, 32'd0, 32'h4E, 1'b0);
    step("popl", 4'hB, 4'h0, 4'h1, 4'h4, 32'd7, 32'h200, 32'd0, 32'h50, 1'b0);
    step("xor_neg", 4'h6, 4'h3, 4'h1, 4'h2, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 32'h52, 1'b0);
    step("jg_neg", 4'h7, 4'h6, 4'hF, 4'hF, 32'd0, 32'd0, 32'h300, 32'h54, 1'b1);

    // reset pulse between edges with an in-flight OPl on the inputs
    icode = 4'h6; ifun = 4'h0; valA = 32'd3; valB = 32'd4; rA = 4'h2; rB = 4'h6;
    #2 reset = 1'b1;
    #1 chk_reset("rst_async");
    @(posedge CLOCK_50);
    #1 chk_reset("rst_edge");
    #3 reset = 1'b0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    step("jne_post_rst", 4'h7, 4'h4, 4'hF, 4'hF, 32'd0, 32'd0, 32'h400, 32'h60, 1'b1);
    step("je_post_rst", 4'h7, 4'h3, 4'hF, 4'hF, 32'd0, 32'd0, 32'h500, 32'h64, 1'b1);

    // random instruction mix, biased toward flag producers and consumers
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [3:0] ic;
      logic [31:0] a, b;
      sel = $urandom_range(0, 9);
      if (sel < 3) ic = 4'h6;
      else if (sel < 5) ic = 4'h7;
      else if (sel < 6) ic = 4'h2;
      else ic = 4'($urandom_range(0, 15));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = {1'b0, 31'h7FFF_FFFF} ^ {32{b[31]}};
      step("rand", ic, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), a, b, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
